tx_data_buffer: RTL and testbench
=================================

# tx_data_buffer

64-byte FIFO that sits directly upstream of `usb_transmitter`. Host-side logic pushes DATA-packet payload bytes into it, and the transmitter pops them through `get_tx_packet_data`. The buffer always presents the head byte on `tx_packet_data` and reports the live byte count on `buffer_occupancy`. The transmitter uses that count to size and terminate DATA0/DATA1 payloads.

## Interface
Parameters:
- `DEPTH`, 64, number of 8-bit entries; must be a power of two; max payload per packet.
- `OCC_W`, 7, occupancy width; equals clog2(DEPTH)+1.

Ports:
- `clk`  in  1  system clock. One clock domain; all state changes on rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `store_tx_data`  in  1  push strobe; one byte per cycle while high.
- `tx_data`  in  8  byte to push.
- `get_tx_packet_data`  in  1  pop strobe from `usb_transmitter`.
- `clear`  in  1  synchronous flush.
- `tx_packet_data`  out  8  head byte; 8'h00 when empty.
- `buffer_occupancy`  out  OCC_W  bytes held, 0..DEPTH.
- `buffer_full`  out  1  high when occupancy == DEPTH.
- `buffer_empty`  out  1  high when occupancy == 0.
- `overflow_err`  out  1  sticky status; see Configuration.
- `underflow_err`  out  1  sticky status; see Configuration.

## Operation
- Storage is a register array of DEPTH x 8 bits.
- Pointers:
  - Write pointer `wptr` and read pointer `rptr` are clog2(DEPTH) bits wide.
  - Both wrap modulo DEPTH (63 -> 0).
  - Occupancy is a separate OCC_W-bit register. It is never derived from the pointers, so full and empty are unambiguous.
- Push accepted = `store_tx_data` && !`clear` && (occupancy < DEPTH || pop accepted).
  - Effect: writes `tx_data` to mem[wptr] and increments `wptr`.
- Pop accepted = `get_tx_packet_data` && !`clear` && occupancy > 0.
  - Effect: increments `rptr`.
- Occupancy update, next cycle:
  - +1 for push only.
  - -1 for pop only.
  - Unchanged when both or neither are accepted.
- Full, simultaneous push+pop: both accepted; occupancy stays at DEPTH.
- Empty, simultaneous push+pop: pop rejected, push accepted; occupancy becomes 1.
- Rejected push while full: byte dropped; no state change.
- Rejected pop while empty: no state change.
- `clear` priority:
  - `clear` overrides push and pop in the same cycle.
  - Next cycle: `wptr` = `rptr` = 0 and occupancy = 0.
  - Memory contents are not cleared.
- Head output: `tx_packet_data` = mem[rptr] when occupancy > 0, else 8'h00. It is a combinational mux from registered state, so it is glitch-free relative to `clk`.
- `buffer_full` and `buffer_empty` are decoded combinationally from the occupancy register.
- Reset mid-packet: all pointers, occupancy and flags return to reset values immediately. Memory is not reset. The transmitter sees occupancy 0.

## Timing
- Reset values:
  - `buffer_occupancy` = 0
  - `tx_packet_data` = 8'h00
  - `buffer_empty` = 1
  - `buffer_full` = 0
  - `overflow_err` = 0
  - `underflow_err` = 0
- Push latency: a byte pushed at edge k is visible on `tx_packet_data` after edge k if the FIFO was empty. Occupancy updates after edge k.
- Pop latency: the pop strobe is sampled at edge k. The next head byte and the decremented occupancy appear after edge k. The transmitter samples the head byte in the same cycle it asserts `get_tx_packet_data`.
- Throughput: one push and one pop per cycle, sustained.
- No combinational path from `store_tx_data` or `get_tx_packet_data` to any output.

## Configuration
- `TX_BUFFER_ERR_FLAGS_EN` defined:
  - `overflow_err` sets on any rejected push (`store_tx_data` while full without an accepted pop).
  - `underflow_err` sets on any `get_tx_packet_data` while empty.
  - Both flags set one cycle after the offending strobe.
  - Both are sticky until `clear` or reset. `clear` wins over a same-cycle set.
- Not defined: both flag outputs are tied to 0 and no flag registers are built. All other behaviour is identical.

## Test plan
- Reset: assert `n_rst`=0 mid-fill with occupancy 5 -> occupancy 0, `tx_packet_data` 8'h00, `buffer_empty` 1, both flags 0.
- Single byte: push 8'h81 -> next cycle occupancy 1 and `tx_packet_data` 8'h81. Pop -> occupancy 0, data 8'h00.
- Fill/wrap:
  - Push 64 bytes alternating 8'h00/8'hFF -> occupancy 64, `buffer_full` 1.
  - A 65th push is dropped; with `TX_BUFFER_ERR_FLAGS_EN`, `overflow_err` is 1.
  - Pop all 64 -> sequence 00,FF,... in order, ending empty.
  - Repeat once to cross the pointer wrap.
- Simultaneous:
  - At occupancy 64, push 8'hA5 with pop -> occupancy stays 64; 8'hA5 emerges 64 pops later.
  - At occupancy 0, push+pop -> occupancy 1.
- Clear priority: at occupancy 10, assert `clear` together with push and pop -> next cycle occupancy 0, data 8'h00, flags cleared.
- Underflow: pop while empty -> occupancy stays 0; `underflow_err` is 1 with the macro defined, 0 without it.

Source files
------------

// File: rtl/tx_data_buffer.sv
// tx_data_buffer: DEPTH x 8-bit FIFO feeding usb_transmitter.
//
// Host logic pushes payload bytes with store_tx_data/tx_data. The transmitter
// reads the head byte on tx_packet_data and pops it with get_tx_packet_data.
// Occupancy is kept in its own register so full and empty are unambiguous.
//
// Ports:
//   clk, n_rst          - clock, asynchronous active-low reset
//   store_tx_data       - push strobe, tx_data is the byte to push
//   get_tx_packet_data  - pop strobe
//   clear               - synchronous flush, overrides push and pop
//   tx_packet_data      - head byte, 8'h00 when empty
//   buffer_occupancy    - bytes held, 0..DEPTH
//   buffer_full/empty   - decoded from occupancy
//   overflow_err        - sticky rejected-push flag
//   underflow_err       - sticky pop-while-empty flag
//
// Build option: define TX_BUFFER_ERR_FLAGS_EN to build the sticky error
// flags. Without it both flag outputs are tied low and no flag state exists.
module tx_data_buffer #(
  parameter int DEPTH = 64,
  parameter int OCC_W = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             store_tx_data,
  input  logic [7:0]       tx_data,
  input  logic             get_tx_packet_data,
  input  logic             clear,
  output logic [7:0]       tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             buffer_full,
  output logic             buffer_empty,
  output logic             overflow_err,
  output logic             underflow_err
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             push_acc, pop_acc;
  logic             is_empty, is_full;

  assign is_empty = (occ_q == '0);
  assign is_full  = (occ_q == OCC_W'(DEPTH));

  // A push into a full buffer is still accepted when a pop frees a slot.
  assign pop_acc  = get_tx_packet_data && !clear && !is_empty;
  assign push_acc = store_tx_data && !clear && (!is_full || pop_acc);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
    end else begin
      if (push_acc) wptr_d = wptr_q + AW'(1);
      if (pop_acc)  rptr_d = rptr_q + AW'(1);
      if (push_acc && !pop_acc)      occ_d = occ_q + OCC_W'(1);
      else if (pop_acc && !push_acc) occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wptr_q] <= tx_data;
  end

  assign tx_packet_data   = is_empty ? 8'h00 : mem_q[rptr_q];
  assign buffer_occupancy = occ_q;
  assign buffer_full      = is_full;
  assign buffer_empty     = is_empty;

`ifdef TX_BUFFER_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // clear wins over a same-cycle set.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clear) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (store_tx_data && !push_acc)   ovf_d = 1'b1;
      if (get_tx_packet_data && is_empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
`else
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_tx_data_buffer.sv
// Bench for tx_data_buffer: queue-based reference model, per-cycle compare on
// the falling edge, directed scenarios with literal expectations, then
// randomized traffic including clears and asynchronous resets.
module tb_tx_data_buffer;
  localparam int DEPTH = 64;
  localparam int OCC_W = 7;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             store_tx_data = 1'b0;
  logic [7:0]       tx_data = 8'h00;
  logic             get_tx_packet_data = 1'b0;
  logic             clear = 1'b0;
  logic [7:0]       tx_packet_data;
  logic [OCC_W-1:0] buffer_occupancy;
  logic             buffer_full, buffer_empty, overflow_err, underflow_err;

  tx_data_buffer #(.DEPTH(DEPTH), .OCC_W(OCC_W)) dut (
    .clk(clk), .n_rst(n_rst),
    .store_tx_data(store_tx_data), .tx_data(tx_data),
    .get_tx_packet_data(get_tx_packet_data), .clear(clear),
    .tx_packet_data(tx_packet_data), .buffer_occupancy(buffer_occupancy),
    .buffer_full(buffer_full), .buffer_empty(buffer_empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

`ifdef TX_BUFFER_ERR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  int vectors = 0;
  int errors  = 0;
  bit check_en = 1'b0;

  // Reference model: a byte queue plus two sticky bits.
  byte unsigned q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (clear) begin
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      bit do_pop, do_push;
      do_pop  = get_tx_packet_data && (q.size() > 0);
      do_push = store_tx_data && ((q.size() < DEPTH) || do_pop);
      if (get_tx_packet_data && q.size() == 0) m_unf = FLAGS;
      if (store_tx_data && !do_push)           m_ovf = FLAGS;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(tx_data);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en && n_rst) begin
      int exp_data;
      exp_data = (q.size() > 0) ? int'(q[0]) : 0;
      chk("occupancy", int'(buffer_occupancy), q.size());
      chk("head_data", int'(tx_packet_data), exp_data);
      chk("full",      int'(buffer_full),  int'(q.size() == DEPTH));
      chk("empty",     int'(buffer_empty), int'(q.size() == 0));
      chk("ovf_flag",  int'(overflow_err),  int'(m_ovf));
      chk("unf_flag",  int'(underflow_err), int'(m_unf));
    end
  end

  // One clock: drive inputs, then land on the following falling edge.
  task automatic cyc(input bit st, input byte unsigned d, input bit gt, input bit cl);
    store_tx_data = st; tx_data = d; get_tx_packet_data = gt; clear = cl;
    @(posedge clk);
    @(negedge clk);
    store_tx_data = 1'b0; get_tx_packet_data = 1'b0; clear = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    check_en = 1'b1;
    @(negedge clk);

    // Reset mid-fill at occupancy 5.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i + 1), 1'b0, 1'b0);
    chk("pre_reset_occ", int'(buffer_occupancy), 5);
    #2 n_rst = 1'b0;
    #1;
    chk("rst_occ",   int'(buffer_occupancy), 0);
    chk("rst_data",  int'(tx_packet_data), 0);
    chk("rst_empty", int'(buffer_empty), 1);
    chk("rst_full",  int'(buffer_full), 0);
    chk("rst_flags", int'({overflow_err, underflow_err}), 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // Single byte.
    cyc(1'b1, 8'h81, 1'b0, 1'b0);
    chk("single_occ",  int'(buffer_occupancy), 1);
    chk("single_data", int'(tx_packet_data), 8'h81);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("single_pop_occ",  int'(buffer_occupancy), 0);
    chk("single_pop_data", int'(tx_packet_data), 0);

    // Fill/overflow/drain, twice to cross the pointer wrap.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, (i % 2) ? 8'hFF : 8'h00, 1'b0, 1'b0);
      chk("fill_occ",  int'(buffer_occupancy), 64);
      chk("fill_full", int'(buffer_full), 1);
      cyc(1'b1, 8'h5A, 1'b0, 1'b0);
      chk("drop_occ", int'(buffer_occupancy), 64);
      chk("ovf_set",  int'(overflow_err), int'(FLAGS));
      for (int i = 0; i < DEPTH; i++) begin
        chk("drain_seq", int'(tx_packet_data), (i % 2) ? 8'hFF : 8'h00);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drain_empty", int'(buffer_empty), 1);
      chk("ovf_sticky",  int'(overflow_err), int'(FLAGS));
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_cleared", int'(overflow_err), 0);
    end

    // Simultaneous push+pop while full.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("full_pp_occ", int'(buffer_occupancy), 64);
    chk("full_pp_ovf", int'(overflow_err), 0);
    for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("a5_head", int'(tx_packet_data), 8'hA5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("a5_drained", int'(buffer_occupancy), 0);

    // Simultaneous push+pop while empty.
    cyc(1'b1, 8'h3C, 1'b1, 1'b0);
    chk("empty_pp_occ",  int'(buffer_occupancy), 1);
    chk("empty_pp_data", int'(tx_packet_data), 8'h3C);
    chk("empty_pp_unf",  int'(underflow_err), int'(FLAGS));

    // Clear priority at occupancy 10 with flags set.
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("pre_clear_occ", int'(buffer_occupancy), 10);
    cyc(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("clear_occ",   int'(buffer_occupancy), 0);
    chk("clear_data",  int'(tx_packet_data), 0);
    chk("clear_flags", int'({overflow_err, underflow_err}), 0);

    // Underflow.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_occ",  int'(buffer_occupancy), 0);
    chk("unf_flag", int'(underflow_err), int'(FLAGS));
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic with phases of push/pop bias.
    for (int i = 0; i < 4000; i++) begin
      int pp, gp;
      pp = ((i / 250) % 2) ? 30 : 75;
      gp = ((i / 250) % 2) ? 75 : 30;
      if ($urandom_range(0, 299) == 0) begin
        #2 n_rst = 1'b0;
        #2 n_rst = 1'b1;
        @(negedge clk);
      end else begin
        cyc(($urandom_range(0, 99) < pp), 8'($urandom), ($urandom_range(0, 99) < gp),
            ($urandom_range(0, 199) == 0));
      end
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
